input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage between the board push-button/slide switches and the guessing-game top level.
- Synchronizes the raw enter key and the 8-bit guess switches into the clk domain, and debounces the enter key with a counter-based FSM.
- Produces a clean enter level, a one-cycle press pulse, and a guess value latched at the accepted press. The game's enter and guess inputs consume these outputs directly.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized cycles required to accept a press or release (10 ms at 50 MHz); legal range 1 to 2^24-1.
- SYNC_STAGES, 2: flip-flop stages in each synchronizer chain; minimum 2.
- KEY_ACTIVE_LOW, 1: 1 means raw key 0 = pressed; 0 means raw key 1 = pressed.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- key_raw  input  1  unsynchronized enter push-button.
- sw_raw  input  8  unsynchronized guess slide switches.
- enter_level  output  1  debounced key state, 1 = pressed.
- enter_pulse  output  1  high for exactly one cycle per accepted press.
- guess  output  8  synchronized switch value captured at the accepted press.
- guess_live  output  8  synchronized switch value, continuously updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - key synchronizer chain loads the released level (1 if KEY_ACTIVE_LOW, else 0).
  - switch chains load 0.
  - state = S_IDLE, counter = 0.
  - enter_level, enter_pulse, guess and guess_live all = 0.
- Synchronization:
  - key_raw and each sw_raw bit pass through SYNC_STAGES flops.
  - key_p = synchronized key normalized to 1 = pressed.
  - guess_live = last switch stage, with latency SYNC_STAGES.
- FSM states: S_IDLE, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT. Counter width = clog2(DEBOUNCE_CYCLES+1).
- S_IDLE: enter_level=0. If key_p=1, go to S_PRESS_WAIT with counter=0.
- S_PRESS_WAIT: enter_level=0.
  - key_p=0: return to S_IDLE (bounce rejected).
  - key_p=1 and counter==DEBOUNCE_CYCLES-1: go to S_PRESSED, capture guess from guess_live, and register enter_pulse=1 for the following cycle.
  - Otherwise: counter+1.
- S_PRESSED: enter_level=1. If key_p=0, go to S_RELEASE_WAIT with counter=0.
- S_RELEASE_WAIT: enter_level=1.
  - key_p=1: return to S_PRESSED, counter=0, no new pulse.
  - key_p=0 and counter==DEBOUNCE_CYCLES-1: go to S_IDLE.
  - Otherwise: counter+1.
- Latency:
  - Raw assert stable before edge 1 gives enter_level=1 and enter_pulse=1 after edge SYNC_STAGES+1+DEBOUNCE_CYCLES.
  - Release is symmetric for enter_level.
- Output timing: enter_level and enter_pulse are registered. enter_pulse is 0 in all other cycles, so it can never be high on consecutive cycles.
- guess stability: guess changes only on an accepted press and stays stable across releases and bounces.
- DEBOUNCE_CYCLES=1: S_PRESS_WAIT and S_RELEASE_WAIT each last one cycle.
- Reset mid-press: immediately return to S_IDLE with outputs cleared. A key held through reset deassertion must re-qualify with the full DEBOUNCE_CYCLES count.
- Switch changes during S_PRESS_WAIT: the value captured is the one present on the accepting edge.

Optional Feature:
- Macro: INCOND_PRESS_COUNT_EN.
- Defined:
  - Adds output press_count [7:0], reset 0.
  - Increments on each cycle where enter_pulse=1.
  - Saturates at 255 with no wrap.
- Undefined: the port and counter do not exist, and all other behaviour is identical.

Decomposition:
- Shared package incond_pkg holds:
  - state enum type incond_state_t (S_IDLE, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT);
  - the DEBOUNCE_CYCLES default constant;
  - the released-level constant.
- One sub-module, sync_chain: parameterized width and SYNC_STAGES, async active-low reset to a parameterized value. It is instantiated twice: 1-bit key, 8-bit switches.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, KEY_ACTIVE_LOW=1):
1. Reset, then key_raw=1 for 20 cycles -> enter_level=0, enter_pulse=0, guess=0 throughout.
2. sw_raw=8'h5A, key_raw=0 held from before edge 1 -> enter_level=1 and enter_pulse=1 after edge 7, enter_pulse=0 after edge 8, guess=8'h5A.
3. key_raw toggled 0/1 every 2 cycles for 30 cycles -> enter_pulse never asserted, enter_level stays 0.
4. Key held pressed, then 2-cycle release glitch -> enter_level stays 1, no second pulse; sw_raw changed to 8'h33 during the glitch leaves guess=8'h5A.
5. Full press/release/press with sw_raw=8'hFF on the second press -> exactly two pulses separated by at least 11 cycles, final guess=8'hFF.
6. reset=0 asserted while in S_PRESS_WAIT, key still held -> outputs 0 immediately; after reset release, pulse fires only after the full SYNC_STAGES+1+4 cycles. With INCOND_PRESS_COUNT_EN, 300 accepted presses give press_count=255.

Source files
------------

// File: rtl/incond_pkg.sv
// Shared types and constants for the push-button/switch input conditioner.
package incond_pkg;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } incond_state_t;

  // 10 ms of stable input at 50 MHz.
  localparam int INCOND_DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Raw key level when the button is not pressed, for an active-low key.
  localparam logic INCOND_KEY_RELEASED_ACTIVE_LOW = 1'b1;

  function automatic logic incond_released_level(input int key_active_low);
    return (key_active_low != 0) ? INCOND_KEY_RELEASED_ACTIVE_LOW
                                 : ~INCOND_KEY_RELEASED_ACTIVE_LOW;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer: latency STAGES cycles, no backpressure.
// Resets asynchronously to RESET_VAL so downstream logic sees a defined idle level.
module sync_chain #(
  parameter int                 WIDTH     = 1,
  parameter int                 STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= i_dat;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_dat = r_stage[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes/debounces the enter key and latches the guess switches; press accepted SYNC_STAGES+1+DEBOUNCE_CYCLES cycles after a stable press, no backpressure.
// Optional INCOND_PRESS_COUNT_EN adds a saturating 8-bit accepted-press counter output.
module input_conditioner
  import incond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = INCOND_DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_raw,
  input  logic [7:0] sw_raw,
  output logic       enter_level,
  output logic       enter_pulse,
  output logic [7:0] guess,
  output logic [7:0] guess_live
`ifdef INCOND_PRESS_COUNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             KEY_RELEASED = incond_released_level(KEY_ACTIVE_LOW);

  logic       w_key_sync;
  logic       w_key_p;
  logic [7:0] w_sw_sync;

  sync_chain #(
    .WIDTH     (1),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (KEY_RELEASED)
  ) u_key_sync (
    .clk   (clk),
    .reset (reset),
    .i_dat (key_raw),
    .o_dat (w_key_sync)
  );

  sync_chain #(
    .WIDTH     (8),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (8'h00)
  ) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .i_dat (sw_raw),
    .o_dat (w_sw_sync)
  );

  assign w_key_p = (KEY_ACTIVE_LOW != 0) ? ~w_key_sync : w_key_sync;

  incond_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_pulse;
  logic [7:0]       r_guess;

  // Level and pulse are registered alongside the state transition so the
  // outputs change on the same edge the debounce decision is made.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_guess <= 8'h00;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_key_p) begin
            r_state <= S_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!w_key_p) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_PRESSED;
            r_level <= 1'b1;
            r_pulse <= 1'b1;
            r_guess <= w_sw_sync;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_PRESSED: begin
          if (!w_key_p) begin
            r_state <= S_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        S_RELEASE_WAIT: begin
          if (w_key_p) begin
            r_state <= S_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign enter_level = r_level;
  assign enter_pulse = r_pulse;
  assign guess       = r_guess;
  assign guess_live  = w_sw_sync;

`ifdef INCOND_PRESS_COUNT_EN
  logic [7:0] r_press_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_press_count <= 8'h00;
    end else if (r_pulse && (r_press_count != 8'hFF)) begin
      r_press_count <= r_press_count + 8'd1;
    end
  end

  assign press_count = r_press_count;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, active-low key.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_raw;
  logic [7:0] sw_raw;
  logic       enter_level;
  logic       enter_pulse;
  logic [7:0] guess;
  logic [7:0] guess_live;
`ifdef INCOND_PRESS_COUNT_EN
  logic [7:0] press_count;
`endif

  int errors = 0;
  int checks = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_raw     (key_raw),
    .sw_raw      (sw_raw),
    .enter_level (enter_level),
    .enter_pulse (enter_pulse),
    .guess       (guess),
    .guess_live  (guess_live)
`ifdef INCOND_PRESS_COUNT_EN
    ,
    .press_count (press_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    key_raw = 1'b1;
    sw_raw  = 8'hA5;
    step();
    step();
    checks++; if (enter_level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b want 0", enter_level); end
    checks++; if (enter_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", enter_pulse); end
    checks++; if (guess !== 8'h00) begin errors++; $display("FAIL reset_guess: got %h want 00", guess); end
    checks++; if (guess_live !== 8'h00) begin errors++; $display("FAIL reset_guess_live: got %h want 00", guess_live); end
`ifdef INCOND_PRESS_COUNT_EN
    checks++; if (press_count !== 8'h00) begin errors++; $display("FAIL reset_press_count: got %0d want 0", press_count); end
`endif
    reset  = 1'b1;
    sw_raw = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++; if (enter_level !== 1'b0) begin errors++; $display("FAIL idle_level cyc %0d: got %b want 0", c, enter_level); end
      checks++; if (enter_pulse !== 1'b0) begin errors++; $display("FAIL idle_pulse cyc %0d: got %b want 0", c, enter_pulse); end
      checks++; if (guess !== 8'h00) begin errors++; $display("FAIL idle_guess cyc %0d: got %h want 00", c, guess); end
    end
  endtask

  task automatic test_press();
    sw_raw  = 8'h5A;
    key_raw = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) begin
        checks++; if (guess_live !== 8'h00) begin errors++; $display("FAIL live_lat1: got %h want 00", guess_live); end
      end
      if (c == 2) begin
        checks++; if (guess_live !== 8'h5A) begin errors++; $display("FAIL live_lat2: got %h want 5a", guess_live); end
      end
      checks++; if (enter_level !== (c >= 7)) begin errors++; $display("FAIL press_level edge %0d: got %b want %b", c, enter_level, (c >= 7)); end
      checks++; if (enter_pulse !== (c == 7)) begin errors++; $display("FAIL press_pulse edge %0d: got %b want %b", c, enter_pulse, (c == 7)); end
    end
    checks++; if (guess !== 8'h5A) begin errors++; $display("FAIL press_guess: got %h want 5a", guess); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int low_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      key_raw = (c == 4 || c == 5) ? 1'b1 : 1'b0;
      if (c >= 4) sw_raw = 8'h33;
      step();
      if (enter_pulse) pulses++;
      if (!enter_level) low_cnt++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
    checks++; if (low_cnt !== 0) begin errors++; $display("FAIL glitch_level_low_cycles: got %0d want 0", low_cnt); end
    checks++; if (guess !== 8'h5A) begin errors++; $display("FAIL glitch_guess: got %h want 5a", guess); end
    checks++; if (guess_live !== 8'h33) begin errors++; $display("FAIL glitch_guess_live: got %h want 33", guess_live); end
  endtask

  task automatic test_release();
    key_raw = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      checks++; if (enter_level !== (c < 7)) begin errors++; $display("FAIL release_level edge %0d: got %b want %b", c, enter_level, (c < 7)); end
      checks++; if (enter_pulse !== 1'b0) begin errors++; $display("FAIL release_pulse edge %0d: got %b want 0", c, enter_pulse); end
    end
    checks++; if (guess !== 8'h5A) begin errors++; $display("FAIL release_guess: got %h want 5a", guess); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int high_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      key_raw = (((i / 2) % 2) == 0) ? 1'b0 : 1'b1;
      step();
      if (enter_pulse) pulses++;
      if (enter_level) high_cnt++;
    end
    key_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (enter_pulse) pulses++;
      if (enter_level) high_cnt++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", pulses); end
    checks++; if (high_cnt !== 0) begin errors++; $display("FAIL bounce_level_high_cycles: got %0d want 0", high_cnt); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first_edge = -1;
    int second_edge = -1;
    logic [7:0] first_guess = 8'h00;
    for (int c = 1; c <= 36; c++) begin
      key_raw = (c <= 12 || c >= 25) ? 1'b0 : 1'b1;
      sw_raw  = (c >= 25) ? 8'hFF : 8'h33;
      step();
      if (enter_pulse) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge  = c;
          first_guess = guess;
        end else begin
          second_edge = c;
        end
      end
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d want 2", pulses); end
    checks++; if (first_edge !== 7) begin errors++; $display("FAIL b2b_first_edge: got %0d want 7", first_edge); end
    checks++; if ((second_edge - first_edge) !== 24) begin errors++; $display("FAIL b2b_gap: got %0d want 24", second_edge - first_edge); end
    checks++; if (first_guess !== 8'h33) begin errors++; $display("FAIL b2b_first_guess: got %h want 33", first_guess); end
    checks++; if (guess !== 8'hFF) begin errors++; $display("FAIL b2b_final_guess: got %h want ff", guess); end
    key_raw = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++; if (enter_level !== 1'b0) begin errors++; $display("FAIL b2b_released: got %b want 0", enter_level); end
  endtask

  task automatic test_capture_edge();
    for (int c = 1; c <= 7; c++) begin
      key_raw = 1'b0;
      sw_raw  = (c < 5) ? 8'h11 : ((c == 5) ? 8'h22 : 8'h44);
      step();
    end
    checks++; if (enter_pulse !== 1'b1) begin errors++; $display("FAIL capture_pulse: got %b want 1", enter_pulse); end
    checks++; if (guess !== 8'h22) begin errors++; $display("FAIL capture_guess: got %h want 22", guess); end
    checks++; if (guess_live !== 8'h44) begin errors++; $display("FAIL capture_guess_live: got %h want 44", guess_live); end
    key_raw = 1'b1;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset_mid_press();
    sw_raw  = 8'h77;
    key_raw = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    checks++; if (enter_level !== 1'b0) begin errors++; $display("FAIL midrst_pre_level: got %b want 0", enter_level); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (enter_level !== 1'b0) begin errors++; $display("FAIL midrst_level: got %b want 0", enter_level); end
    checks++; if (enter_pulse !== 1'b0) begin errors++; $display("FAIL midrst_pulse: got %b want 0", enter_pulse); end
    checks++; if (guess !== 8'h00) begin errors++; $display("FAIL midrst_guess: got %h want 00", guess); end
    checks++; if (guess_live !== 8'h00) begin errors++; $display("FAIL midrst_guess_live: got %h want 00", guess_live); end
    for (int c = 1; c <= 3; c++) step();
    reset = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++; if (enter_pulse !== (c == 7)) begin errors++; $display("FAIL midrst_requal_pulse edge %0d: got %b want %b", c, enter_pulse, (c == 7)); end
      checks++; if (enter_level !== (c >= 7)) begin errors++; $display("FAIL midrst_requal_level edge %0d: got %b want %b", c, enter_level, (c >= 7)); end
    end
    checks++; if (guess !== 8'h77) begin errors++; $display("FAIL midrst_guess_after: got %h want 77", guess); end
  endtask

`ifdef INCOND_PRESS_COUNT_EN
  task automatic test_press_count();
    checks++; if (press_count !== 8'd1) begin errors++; $display("FAIL pcount_after_reset_press: got %0d want 1", press_count); end
    key_raw = 1'b1;
    for (int c = 0; c < 9; c++) step();
    for (int i = 0; i < 300; i++) begin
      key_raw = 1'b0;
      for (int c = 0; c < 9; c++) step();
      key_raw = 1'b1;
      for (int c = 0; c < 9; c++) step();
      if (i == 99) begin
        checks++; if (press_count !== 8'd101) begin errors++; $display("FAIL pcount_mid: got %0d want 101", press_count); end
      end
    end
    checks++; if (press_count !== 8'd255) begin errors++; $display("FAIL pcount_saturate: got %0d want 255", press_count); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_release();
    test_bounce();
    test_back_to_back();
    test_capture_edge();
    test_reset_mid_press();
`ifdef INCOND_PRESS_COUNT_EN
    test_press_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
